comp_freq_seq: RTL and testbench
================================

# comp_freq_seq

Parametrised successor of the TERO comparison-frequency counter. It decodes an 8-bit challenge into an unordered pair of TERO groups (i, j), then steps through every TERO index of group i and then of group j, across all banks, one index per `increment`. It sits between the challenge front-end and the TERO measurement mux/counter. Over the earlier counter it adds parametric geometry, a start/valid handshake, a selectable walk order, and an optional out-of-range challenge check.

## Interface
Parameters:
- `N_GROUPS`, 16: TERO groups per bank; even, power of 2.
- `GROUP_SIZE`, 8: TEROs per group; power of 2.
- `N_BANKS`, 10: replicated banks.
- `CH_W`, 8: challenge width.
- `IDX_W`, `$clog2(N_BANKS*N_GROUPS*GROUP_SIZE)` (11 at defaults): TERO index width.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset; synchronous, active-low.
- `start`, in, 1: capture `challenge_in` and (re)start the walk.
- `challenge_in`, in, CH_W: pair code; sampled only on `start`.
- `bank_major`, in, 1: walk order; sampled only on `start`.
- `increment`, in, 1: advance to the next TERO index.
- `next_TERO`, out, IDX_W: current TERO index.
- `out_valid`, out, 1: `next_TERO` is meaningful.
- `half`, out, 1: 0 while walking group i, 1 while walking group j.
- `pair_i`, out, `$clog2(N_GROUPS)`: decoded first group.
- `pair_j`, out, `$clog2(N_GROUPS)`: decoded second group.
- `done`, out, 1: walk complete.
- `err`, out, 1: challenge out of range (see Configuration).

## Operation
- Index formula: `next_TERO = bank*(N_GROUPS*GROUP_SIZE) + group*GROUP_SIZE + member`, unsigned, IDX_W bits.
- Pair decode, with G = N_GROUPS, r = challenge/G and c = challenge%G:
  - if c < G-1-r: i = r, j = r+1+c;
  - else: i = G-2-r, j = c.
  - Valid codes are 0 .. G(G-1)/2-1 (0..119 at defaults). Every unordered pair appears exactly once.
- Walk order:
  - `bank_major=0`: bank is the innermost loop, then member. Group i is walked completely before group j.
  - `bank_major=1`: member is the innermost loop, then bank.
- Steps per walk: 2·GROUP_SIZE·N_BANKS (160 at defaults).
- FSM states:
  - IDLE: `out_valid=0`. `start` → DECODE.
  - DECODE: register `pair_i`/`pair_j`; clear the counters. → RUN.
  - RUN: `out_valid=1`. `increment` advances. On the last step, `increment` → DONE.
  - DONE: `done=1`; `next_TERO` holds its last value; `out_valid=0`; `increment` is ignored.
- `start` in any state (including RUN and DONE) aborts the current walk and goes to DECODE with the new challenge.
- `start` and `increment` asserted in the same cycle: `start` wins.
- `increment` is ignored in IDLE and DECODE.
- `reset_n=0` (including mid-walk) → IDLE. Reset values of all outputs: 0.

## Timing
- `start` sampled at edge N → DECODE during cycle N..N+1. From edge N+1: RUN, `out_valid=1`, `next_TERO` = first index.
- `increment` high at edge M → new index visible after edge M. One step per cycle is permitted (back-to-back `increment`).
- `half` rises in the same cycle `next_TERO` first shows a group-j index.
- `done` rises one edge after the `increment` that consumed the final index.
- `pair_i`/`pair_j` are stable from edge N+1 until the next `start` or reset.

## Configuration
- `COMP_FREQ_RANGE_CHK_EN` defined:
  - In DECODE, a code ≥ G(G-1)/2 sets `err=1` and goes straight to DONE. `out_valid` never rises and `done=1`.
  - `err` clears on the next `start` or reset.
- Undefined: no range check; the decode formula is applied as-is; `err` is tied to 0.

## Structure
- `comp_freq_pkg`:
  - default geometry constants;
  - FSM state enum `{IDLE, DECODE, RUN, DONE}`;
  - `pair_count(G)` function.
- Sub-module `comp_pair_decode`: combinational challenge → (i, j, in_range). It is registered by the parent in DECODE.
- Parent contains: FSM; member/bank/half counters with order-dependent carry chain; index multiply-add via constant shifts/adds.

## Test plan
All scenarios use default parameters.
- Challenge 14, `bank_major=0`:
  - indices 0, 128, …, 1152, 1 (11th), 120 (81st), 1279 (160th);
  - `done` after 160 increments;
  - 10 extra increments leave 1279 unchanged.
- Challenge 58 → `pair_i=3`, `pair_j=14`; 1st=24, 11th=25, 81st=112, 160th=1271.
- Challenge 61 → (11, 13): 1st=88, 81st=104.
- Challenge 14, `bank_major=1` → 0, 1, …, 7, 128, 129 …; 81st=120; `half` rises at step 81.
- Reset mid-walk at step 50, then `start` with 14 → first index 0, full 160-step sequence repeats identically.
- Challenge 120 with `COMP_FREQ_RANGE_CHK_EN` → `err=1`, `done=1`, `out_valid=0` one edge after DECODE. Without the macro → `err=0`.

Source files
------------

// File: rtl/comp_freq_pkg.sv
// Shared geometry defaults, FSM state type and pair-count helper for comp_freq_seq.
package comp_freq_pkg;

  localparam int unsigned DEF_N_GROUPS   = 16;
  localparam int unsigned DEF_GROUP_SIZE = 8;
  localparam int unsigned DEF_N_BANKS    = 10;
  localparam int unsigned DEF_CH_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of unordered group pairs, i.e. number of valid challenge codes.
  function automatic int unsigned pair_count(input int unsigned g);
    return (g * (g - 1)) / 2;
  endfunction

endpackage

// File: rtl/comp_pair_decode.sv
// Combinational challenge -> unordered group pair (i, j) decoder with range flag.
module comp_pair_decode
  import comp_freq_pkg::*;
#(
  parameter int unsigned N_GROUPS = DEF_N_GROUPS,
  parameter int unsigned CH_W     = DEF_CH_W,
  parameter int unsigned GW       = $clog2(N_GROUPS)
) (
  input  logic [CH_W-1:0] challenge,
  output logic [GW-1:0]   pair_i,
  output logic [GW-1:0]   pair_j,
  output logic            in_range
);

  // One spare bit so row + column never wraps before the compare.
  localparam int unsigned SW = CH_W + 1;

  logic [SW-1:0] ch_ext;
  logic [SW-1:0] row;
  logic [SW-1:0] col;
  logic          upper;

  assign ch_ext = SW'(challenge);
  assign row    = ch_ext >> GW;
  assign col    = SW'(challenge[GW-1:0]);

  // Codes whose column lies left of the folded diagonal map to (r, r+1+c).
  assign upper = (row + col) < SW'(N_GROUPS - 1);

  // Pair selection: upper triangle directly, lower triangle folded back.
  always_comb begin
    pair_i = GW'(row);
    pair_j = GW'(row + col + SW'(1));
    if (!upper) begin
      pair_i = GW'(SW'(N_GROUPS - 2) - row);
      pair_j = GW'(col);
    end
  end

  assign in_range = 32'(challenge) < pair_count(N_GROUPS);

endmodule

// File: rtl/comp_freq_seq.sv
// TERO comparison-frequency sequencer: walks every TERO of group i then group j
// across all banks, one index per increment.
// Optional build macro: COMP_FREQ_RANGE_CHK_EN (out-of-range challenge -> err, DONE).
module comp_freq_seq
  import comp_freq_pkg::*;
#(
  parameter int unsigned N_GROUPS   = DEF_N_GROUPS,
  parameter int unsigned GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int unsigned N_BANKS    = DEF_N_BANKS,
  parameter int unsigned CH_W       = DEF_CH_W,
  parameter int unsigned IDX_W      = $clog2(N_BANKS * N_GROUPS * GROUP_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [CH_W-1:0]             challenge_in,
  input  logic                        bank_major,
  input  logic                        increment,
  output logic [IDX_W-1:0]            next_TERO,
  output logic                        out_valid,
  output logic                        half,
  output logic [$clog2(N_GROUPS)-1:0] pair_i,
  output logic [$clog2(N_GROUPS)-1:0] pair_j,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned GW = $clog2(N_GROUPS);
  localparam int unsigned MW = $clog2(GROUP_SIZE);
  localparam int unsigned BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned CW = BW + GW + MW;

  state_t          state;
  state_t          state_next;
  logic            valid_d;
  logic            done_d;
  logic [CH_W-1:0] chal_q;
  logic            order_q;
  logic [MW-1:0]   member;
  logic [BW-1:0]   bank;
  logic [GW-1:0]   dec_i;
  logic [GW-1:0]   dec_j;
  logic            in_range;
  logic            member_last;
  logic            bank_last;
  logic            last_step;
  logic            advance;
  logic [GW-1:0]   group;
  logic [CW-1:0]   idx_full;

  comp_pair_decode #(
    .N_GROUPS (N_GROUPS),
    .CH_W     (CH_W),
    .GW       (GW)
  ) u_decode (
    .challenge (chal_q),
    .pair_i    (dec_i),
    .pair_j    (dec_j),
    .in_range  (in_range)
  );

  assign member_last = (member == MW'(GROUP_SIZE - 1));
  assign bank_last   = (bank == BW'(N_BANKS - 1));
  assign last_step   = half && member_last && bank_last;
  assign advance     = (state == RUN) && increment && !start && !last_step;

  // State register plus registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= valid_d;
      done      <= done_d;
    end
  end

  // Next-state logic; start overrides everything else.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = DECODE;
    end else begin
      unique case (state)
        IDLE:   state_next = IDLE;
`ifdef COMP_FREQ_RANGE_CHK_EN
        DECODE: state_next = in_range ? RUN : DONE;
`else
        DECODE: state_next = RUN;
`endif
        RUN:    if (increment && last_step) state_next = DONE;
        DONE:   state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state, captured by the state register.
  always_comb begin
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (state_next == RUN)  valid_d = 1'b1;
    if (state_next == DONE) done_d  = 1'b1;
  end

  // Challenge/order capture, pair registration and the walk counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chal_q  <= '0;
      order_q <= 1'b0;
      pair_i  <= '0;
      pair_j  <= '0;
      member  <= '0;
      bank    <= '0;
      half    <= 1'b0;
    end else begin
      if (start) begin
        chal_q  <= challenge_in;
        order_q <= bank_major;
      end
      if (state == DECODE) begin
        pair_i <= dec_i;
        pair_j <= dec_j;
        member <= '0;
        bank   <= '0;
        half   <= 1'b0;
      end else if (advance) begin
        if (!order_q) begin
          if (bank_last) begin
            bank <= '0;
            if (member_last) begin
              member <= '0;
              half   <= 1'b1;
            end else begin
              member <= member + MW'(1);
            end
          end else begin
            bank <= bank + BW'(1);
          end
        end else begin
          if (member_last) begin
            member <= '0;
            if (bank_last) begin
              bank <= '0;
              half <= 1'b1;
            end else begin
              bank <= bank + BW'(1);
            end
          end else begin
            member <= member + MW'(1);
          end
        end
      end
    end
  end

  // Power-of-two geometry turns bank*NG*GS + group*GS + member into a concatenation.
  assign group     = half ? pair_j : pair_i;
  assign idx_full  = {bank, group, member};
  assign next_TERO = IDX_W'(idx_full);

`ifdef COMP_FREQ_RANGE_CHK_EN
  // Sticky range error, cleared by a new start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (state == DECODE && !in_range) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_range;
  assign unused_range = in_range;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_comp_freq_seq.sv
// Self-checking bench for comp_freq_seq (default geometry).
module tb_comp_freq_seq;

  localparam int NG    = 16;
  localparam int GS    = 8;
  localparam int NB    = 10;
  localparam int STEPS = 2 * GS * NB;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  challenge_in;
  logic        bank_major;
  logic        increment;
  logic [10:0] next_TERO;
  logic        out_valid;
  logic        half;
  logic [3:0]  pair_i;
  logic [3:0]  pair_j;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int seq_cur[STEPS];
  int ref14[STEPS];

  comp_freq_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .challenge_in (challenge_in),
    .bank_major   (bank_major),
    .increment    (increment),
    .next_TERO    (next_TERO),
    .out_valid    (out_valid),
    .half         (half),
    .pair_i       (pair_i),
    .pair_j       (pair_j),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference pair decode, straight from the row/column rule.
  task automatic ref_decode(input int ch, output int i, output int j);
    int r, c;
    r = ch / NG;
    c = ch % NG;
    if (c < NG - 1 - r) begin
      i = r;
      j = r + 1 + c;
    end else begin
      i = NG - 2 - r;
      j = c;
    end
  endtask

  // Expected index of 0-based step k, computed in closed form.
  function automatic int exp_idx(input int i, input int j, input int bm, input int k);
    int per, h, r, b, m, g;
    per = GS * NB;
    h   = k / per;
    r   = k % per;
    if (bm == 0) begin
      m = r / NB;
      b = r % NB;
    end else begin
      b = r / GS;
      m = r % GS;
    end
    g = (h != 0) ? j : i;
    return b * NG * GS + g * GS + m;
  endfunction

  // Start a walk and follow it until stop_at indices were shown; a full walk also checks DONE.
  task automatic walk(input int ch, input int bm, input int stop_at);
    int ei, ej, shown, cyc, exp_last;
    bit inc;
    ref_decode(ch, ei, ej);
    start        = 1'b1;
    challenge_in = 8'(ch);
    bank_major   = bm[0];
    increment    = 1'($urandom % 2);
    tick();
    start     = 1'b0;
    increment = 1'($urandom % 2);
    check("decode_out_valid", 32'(out_valid), 32'd0);
    tick();
    increment = 1'b0;
    check("pair_i", 32'(pair_i), 32'(ei));
    check("pair_j", 32'(pair_j), 32'(ej));
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_idx", 32'(next_TERO), 32'(exp_idx(ei, ej, bm, 0)));
    seq_cur[0] = int'(next_TERO);
    shown = 1;
    cyc   = 0;
    while (shown < stop_at && cyc < 4 * stop_at + 50) begin
      inc       = ($urandom % 4) != 0;
      increment = inc;
      tick();
      increment = 1'b0;
      cyc++;
      if (inc) shown++;
      check("run_idx", 32'(next_TERO), 32'(exp_idx(ei, ej, bm, shown - 1)));
      check("run_half", 32'(half), 32'((shown - 1) >= GS * NB));
      check("run_valid", 32'(out_valid), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_err", 32'(err), 32'd0);
      seq_cur[shown - 1] = int'(next_TERO);
    end
    check("walk_progress", 32'(shown), 32'(stop_at));
    if (stop_at == STEPS) begin
      exp_last  = exp_idx(ei, ej, bm, STEPS - 1);
      increment = 1'b1;
      tick();
      check("done_rise", 32'(done), 32'd1);
      check("done_valid", 32'(out_valid), 32'd0);
      check("done_idx", 32'(next_TERO), 32'(exp_last));
      for (int n = 0; n < 10; n++) tick();
      increment = 1'b0;
      check("done_hold_idx", 32'(next_TERO), 32'(exp_last));
      check("done_hold", 32'(done), 32'd1);
    end
  endtask

  initial begin
    int rch, rbm, rlen;
    reset_n      = 1'b0;
    start        = 1'b0;
    challenge_in = '0;
    bank_major   = 1'b0;
    increment    = 1'b0;
    tick();
    tick();
    check("rst_idx", 32'(next_TERO), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_half", 32'(half), 32'd0);
    check("rst_pair_i", 32'(pair_i), 32'd0);
    check("rst_pair_j", 32'(pair_j), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;

    // Increment in IDLE does nothing.
    increment = 1'b1;
    tick();
    tick();
    increment = 1'b0;
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_idx", 32'(next_TERO), 32'd0);

    // Challenge 14, bank-major off.
    walk(14, 0, STEPS);
    check("c14_s1", 32'(seq_cur[0]), 32'd0);
    check("c14_s2", 32'(seq_cur[1]), 32'd128);
    check("c14_s10", 32'(seq_cur[9]), 32'd1152);
    check("c14_s11", 32'(seq_cur[10]), 32'd1);
    check("c14_s81", 32'(seq_cur[80]), 32'd120);
    check("c14_s160", 32'(seq_cur[159]), 32'd1279);
    for (int k = 0; k < STEPS; k++) ref14[k] = seq_cur[k];

    // Challenge 58 -> (3, 14).
    walk(58, 0, STEPS);
    check("c58_pi", 32'(pair_i), 32'd3);
    check("c58_pj", 32'(pair_j), 32'd14);
    check("c58_s1", 32'(seq_cur[0]), 32'd24);
    check("c58_s11", 32'(seq_cur[10]), 32'd25);
    check("c58_s81", 32'(seq_cur[80]), 32'd112);
    check("c58_s160", 32'(seq_cur[159]), 32'd1271);

    // Challenge 61 -> (11, 13), aborted by the next start mid-walk.
    walk(61, 0, 81);
    check("c61_pi", 32'(pair_i), 32'd11);
    check("c61_pj", 32'(pair_j), 32'd13);
    check("c61_s1", 32'(seq_cur[0]), 32'd88);
    check("c61_s81", 32'(seq_cur[80]), 32'd104);

    // Challenge 14, bank-major on.
    walk(14, 1, STEPS);
    for (int k = 0; k < GS; k++) check("bm_member", 32'(seq_cur[k]), 32'(k));
    check("bm_s9", 32'(seq_cur[8]), 32'd128);
    check("bm_s10", 32'(seq_cur[9]), 32'd129);
    check("bm_s81", 32'(seq_cur[80]), 32'd120);

    // Reset in the middle of a walk, then repeat challenge 14.
    walk(14, 0, 50);
    reset_n = 1'b0;
    tick();
    check("mid_rst_idx", 32'(next_TERO), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_half", 32'(half), 32'd0);
    check("mid_rst_pair_j", 32'(pair_j), 32'd0);
    reset_n = 1'b1;
    tick();
    walk(14, 0, STEPS);
    for (int k = 0; k < STEPS; k++) check("repeat14", 32'(seq_cur[k]), 32'(ref14[k]));

    // Out-of-range challenge.
`ifdef COMP_FREQ_RANGE_CHK_EN
    start        = 1'b1;
    challenge_in = 8'd120;
    tick();
    start = 1'b0;
    check("oor_decode_valid", 32'(out_valid), 32'd0);
    tick();
    check("oor_err", 32'(err), 32'd1);
    check("oor_done", 32'(done), 32'd1);
    check("oor_valid", 32'(out_valid), 32'd0);
    increment = 1'b1;
    tick();
    tick();
    increment = 1'b0;
    check("oor_err_hold", 32'(err), 32'd1);
    check("oor_valid_hold", 32'(out_valid), 32'd0);
    walk(119, 0, 5);
    check("oor_err_clear", 32'(err), 32'd0);
`else
    walk(120, 0, STEPS);
    check("oor_pi", 32'(pair_i), 32'd7);
    check("oor_pj", 32'(pair_j), 32'd8);
    check("oor_err", 32'(err), 32'd0);
`endif

    // Randomized walks: random codes, order and lengths, some aborted by the next start.
    for (int w = 0; w < 6; w++) begin
      rch  = int'($urandom_range(0, 119));
      rbm  = int'($urandom % 2);
      rlen = (w % 2 == 0) ? STEPS : int'($urandom_range(1, STEPS));
      walk(rch, rbm, rlen);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
